decode_cycle: RTL and testbench

- Decode stage of the 5-stage RV32I pipeline; sits directly downstream of the fetch stage and consumes InstrD, PCD and PCPlus4D.
- Contains the 32x32 register file (written from writeback), main/ALU control decoder and immediate extender.
- Registers all results into the ID/EX pipeline register feeding the execute stage.

---
 rtl/decode_cycle.sv | 126 ++++++++++++
 tb/tb_decode_cycle.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage with register file, control decoder, immediate extender and ID/EX register
//   in : clk, rst (async, active-low), InstrD/PCD/PCPlus4D from fetch,
//        RegWriteW/RDW/ResultW from writeback, FlushE bubble request
//   out: registered controls, operands, immediate, register addresses and PCs for execute
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RDE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);
    typedef enum logic [2:0] {IMM_N, IMM_I, IMM_S, IMM_B, IMM_J} imm_t;
    typedef struct packed {
        logic            reg_write, mem_write, jump, branch, alu_src;
        logic [1:0]      result_src;
        logic [2:0]      alu_ctrl;
        logic [XLEN-1:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]      rs1, rs2, rd;
    } idex_t;
    logic [XLEN-1:0] rf [NREGS];
    logic [6:0]      op;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2;
    logic            wr_hit;
    logic            reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]      result_src, alu_op;
    logic [2:0]      alu_ctrl;
    imm_t            imm_src;
    logic [XLEN-1:0] imm, rd1, rd2;
    idex_t           d, q;
    assign op     = InstrD[6:0];
    assign f3     = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign wr_hit = RegWriteW && RDW != '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        else if (wr_hit)
            rf[RDW] <= ResultW;
    // a write landing this cycle is forwarded so decode never sees stale data
    assign rd1 = rs1 == '0 ? '0 : (wr_hit && RDW == rs1) ? ResultW : rf[rs1];
    assign rd2 = rs2 == '0 ? '0 : (wr_hit && RDW == rs2) ? ResultW : rf[rs2];
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        result_src = 2'b00;
        alu_op     = 2'b00;
        imm_src    = IMM_N;
        case (op)
            7'b0000011: begin reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; result_src = 2'b01; end
            7'b0100011: begin mem_write = 1'b1; imm_src = IMM_S; alu_src = 1'b1; end
            7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
            7'b0010011: begin reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; alu_op = 2'b10; end
            7'b1100011: begin branch = 1'b1; imm_src = IMM_B; alu_op = 2'b01; end
            7'b1101111: begin reg_write = 1'b1; jump = 1'b1; imm_src = IMM_J; result_src = 2'b10; end
            default: ;
        endcase
    end
    // InstrD[30] selects sub only for R-type; for addi it is just an immediate bit
    assign alu_ctrl = alu_op == 2'b01 ? 3'b001 :
                      alu_op != 2'b10 ? 3'b000 :
                      f3 == 3'b000    ? {2'b00, op == 7'b0110011 && InstrD[30]} :
                      f3 == 3'b010    ? 3'b101 :
                      f3 == 3'b110    ? 3'b011 :
                      f3 == 3'b111    ? 3'b010 : 3'b000;
    always_comb begin
        imm = '0;
        case (imm_src)
            IMM_I:   imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   imm = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
    assign d = '{reg_write: reg_write, mem_write: mem_write, jump: jump, branch: branch,
                 alu_src: alu_src, result_src: result_src, alu_ctrl: alu_ctrl,
                 rd1: rd1, rd2: rd2, imm: imm, pc: PCD, pc4: PCPlus4D,
                 rs1: rs1, rs2: rs2, rd: InstrD[11:7]};
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q <= '0;
        else
            q <= FlushE ? '0 : d;
    assign RegWriteE   = q.reg_write;
    assign MemWriteE   = q.mem_write;
    assign JumpE       = q.jump;
    assign BranchE     = q.branch;
    assign ALUSrcE     = q.alu_src;
    assign ResultSrcE  = q.result_src;
    assign ALUControlE = q.alu_ctrl;
    assign RD1E        = q.rd1;
    assign RD2E        = q.rd2;
    assign ImmExtE     = q.imm;
    assign Rs1E        = q.rs1;
    assign Rs2E        = q.rs2;
    assign RDE         = q.rd;
    assign PCE         = q.pc;
    assign PCPlus4E    = q.pc4;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed plus randomized checks of decode_cycle against an instruction-level model
module tb_decode_cycle;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
    logic        RegWriteW = 1'b0, FlushE = 1'b0;
    logic [4:0]  RDW = '0;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RDE;
    int tests = 0, fails = 0;
    logic [31:0] m_rf [32];
    logic [9:0]  x_ctrl;
    logic [31:0] x_rd1, x_rd2, x_imm;
    logic [14:0] x_regs;
    logic [63:0] x_pc;
    always #5 clk = ~clk;
    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RDE(RDE),
        .PCE(PCE), .PCPlus4E(PCPlus4E)
    );
    function automatic logic [31:0] sx(logic [31:0] v, int n);
        return v[n-1] ? v - (32'd1 << n) : v;
    endfunction
    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic chk_all();
        chk("ctrl", {54'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE}, {54'd0, x_ctrl});
        chk("rd1", {32'd0, RD1E}, {32'd0, x_rd1});
        chk("rd2", {32'd0, RD2E}, {32'd0, x_rd2});
        chk("imm", {32'd0, ImmExtE}, {32'd0, x_imm});
        chk("regs", {49'd0, Rs1E, Rs2E, RDE}, {49'd0, x_regs});
        chk("pc", {PCE, PCPlus4E}, x_pc);
    endtask
    task automatic expect_zero();
        x_ctrl = '0; x_rd1 = '0; x_rd2 = '0; x_imm = '0; x_regs = '0; x_pc = '0;
    endtask
    // model: architectural effect of one decode cycle, written from the instruction tables
    task automatic predict();
        logic [31:0] i = InstrD;
        logic [2:0]  f3 = i[14:12];
        logic rw = 0, mw = 0, j = 0, b = 0, as = 0;
        logic [1:0] rs = 0;
        logic [2:0] ac = 0;
        logic [31:0] imm = 0;
        case (i[6:0])
            7'h03: begin rw = 1; as = 1; rs = 1; imm = sx({20'd0, i[31:20]}, 12); end
            7'h23: begin mw = 1; as = 1; imm = sx({20'd0, i[31:25], i[11:7]}, 12); end
            7'h63: begin b = 1; ac = 1; imm = sx({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13); end
            7'h6F: begin rw = 1; j = 1; rs = 2; imm = sx({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21); end
            7'h33, 7'h13: begin
                rw = 1;
                if (i[6:0] == 7'h13) begin as = 1; imm = sx({20'd0, i[31:20]}, 12); end
                if (f3 == 0) ac = (i[6:0] == 7'h33 && i[30]) ? 3'd1 : 3'd0;
                else if (f3 == 2) ac = 5;
                else if (f3 == 6) ac = 3;
                else if (f3 == 7) ac = 2;
            end
            default: ;
        endcase
        // the write performed at this edge is visible to this cycle's reads
        if (RegWriteW && RDW != 0) m_rf[RDW] = ResultW;
        x_ctrl = {rw, mw, j, b, as, rs, ac};
        x_rd1  = i[19:15] == 0 ? 32'd0 : m_rf[i[19:15]];
        x_rd2  = i[24:20] == 0 ? 32'd0 : m_rf[i[24:20]];
        x_imm  = imm;
        x_regs = {i[19:15], i[24:20], i[11:7]};
        x_pc   = {PCD, PCPlus4D};
        if (FlushE) expect_zero();
    endtask
    task automatic step(logic [31:0] instr, logic wr, logic [4:0] rd, logic [31:0] res, logic fl);
        InstrD = instr; RegWriteW = wr; RDW = rd; ResultW = res; FlushE = fl;
        PCD = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        PCPlus4D = PCD + 4;
        predict();
        @(posedge clk);
        #1;
        chk_all();
    endtask
    task automatic clear_model();
        for (int k = 0; k < 32; k++) m_rf[k] = '0;
    endtask
    initial begin
        logic [6:0]  ops [7];
        logic [31:0] r;
        clear_model();
        InstrD = 32'h00500093;
        #1 rst = 1'b0;
        #11;
        expect_zero();
        chk_all();
        rst = 1'b1;
        step(32'h00500093, 0, 0, 0, 0);
        chk("addi_imm", {32'd0, ImmExtE}, 64'd5);
        chk("addi_rd", {59'd0, RDE}, 64'd1);
        step(32'h003181B3, 1, 3, 32'hDEADBEEF, 0);
        chk("bypass_rd1", {32'd0, RD1E}, 64'hDEADBEEF);
        chk("bypass_rd2", {32'd0, RD2E}, 64'hDEADBEEF);
        step(32'h003181B3, 0, 0, 0, 0);
        chk("stored_rd1", {32'd0, RD1E}, 64'hDEADBEEF);
        step(32'h00000033, 1, 0, 32'h1234, 0);
        chk("x0_rd1", {32'd0, RD1E}, 64'd0);
        step(32'h00000033, 0, 0, 0, 0);
        chk("x0_after", {32'd0, RD2E}, 64'd0);
        step(32'hFE112E23, 0, 0, 0, 0);
        chk("sw_imm", {32'd0, ImmExtE}, 64'hFFFFFFFC);
        step(32'hFE0008E3, 0, 0, 0, 0);
        chk("beq_imm", {32'd0, ImmExtE}, 64'hFFFFFFF0);
        chk("beq_alu", {61'd0, ALUControlE}, 64'd1);
        step(32'h0080006F, 0, 0, 0, 0);
        chk("jal_imm", {32'd0, ImmExtE}, 64'd8);
        chk("jal_res", {62'd0, ResultSrcE}, 64'd2);
        step(32'h40208133, 0, 0, 0, 0);
        chk("sub_alu", {61'd0, ALUControlE}, 64'd1);
        step(32'h0020A133, 0, 0, 0, 0);
        chk("slt_alu", {61'd0, ALUControlE}, 64'd5);
        step(32'h40008093, 0, 0, 0, 0);
        chk("addi30_alu", {61'd0, ALUControlE}, 64'd0);
        step(32'h0000A103, 1, 5, 32'hCAFE0005, 1);
        chk("flush_pc", {PCE, PCPlus4E}, 64'd0);
        step(32'h005280B3, 0, 0, 0, 0);
        chk("flush_wr", {32'd0, RD1E}, 64'hCAFE0005);
        step(32'h0000007F, 0, 0, 0, 0);
        chk("nop_ctrl", {54'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE}, 64'd0);
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            ops[6] = 7'($urandom);
            r[6:0] = ops[$urandom_range(0, 6)];
            step(r, 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, $urandom_range(0, 7) == 0);
        end
        step(32'h003181B3, 1, 3, 32'h0BADF00D, 0);
        #2 rst = 1'b0;
        #1;
        clear_model();
        expect_zero();
        chk_all();
        @(posedge clk);
        #1;
        chk_all();
        rst = 1'b1;
        step(32'h003181B3, 0, 0, 0, 0);
        chk("rst_lost", {32'd0, RD1E}, 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
